// File: rtl/wshb_arbiter.sv
// wshb_arbiter -- two-master Wishbone arbiter in front of a single SDRAM slave.
//
// Master 0 is the video reader, master 1 the frame writer. The selected
// master's request bundle is routed to the slave combinationally; the slave
// response is routed back to the owner only. Every change of ownership passes
// through IDLE, so a handover always costs one cycle with s_cyc low.
//
// A burst counter counts completed transfers (ack or err) of the current
// owner. When the owner completes its MAX_BURST-th transfer while the other
// master is requesting, the arbiter drops to IDLE and records a handover so
// the next grant goes to the waiting master. MAX_BURST = 0 disables this.
//
// Optional feature (macro WSHB_ARBITER_ROUND_ROBIN_EN):
//   defined   -- simultaneous requests from IDLE go to the master not granted
//                last (a priority pointer flop tracks this).
//   undefined -- simultaneous requests from IDLE go to master 0.
//
// Ports:
//   wshb_clk, wshb_rst_n        clock, async active-low reset
//   m0_* / m1_*                 master request in, dat_sm/ack/err out
//   s_*                         slave request out, dat_sm/ack/err in
//   grant[1:0]                  one-hot owner (bit0 = m0, bit1 = m1), 00 idle
module wshb_arbiter #(
  parameter int MAX_BURST = 64
) (
  input  logic        wshb_clk,
  input  logic        wshb_rst_n,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_ms,
  input  logic [3:0]  m0_sel,
  input  logic [2:0]  m0_cti,
  input  logic [1:0]  m0_bte,
  output logic [31:0] m0_dat_sm,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_ms,
  input  logic [3:0]  m1_sel,
  input  logic [2:0]  m1_cti,
  input  logic [1:0]  m1_bte,
  output logic [31:0] m1_dat_sm,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_ms,
  output logic [3:0]  s_sel,
  output logic [2:0]  s_cti,
  output logic [1:0]  s_bte,
  input  logic [31:0] s_dat_sm,
  input  logic        s_ack,
  input  logic        s_err,
  output logic [1:0]  grant
);

  // Counter must hold 0..MAX_BURST; keep at least one bit when MAX_BURST = 0.
  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_e;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
  } wb_req_t;

  wb_req_t m0_req, m1_req, s_req;

  assign m0_req = {m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_ms, m0_sel, m0_cti, m0_bte};
  assign m1_req = {m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_ms, m1_sel, m1_cti, m1_bte};
  assign {s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel, s_cti, s_bte} = s_req;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // One-hot target of a pending forced handover (bit1 = hand to m1).
  logic [1:0]    ho_q, ho_d;
`ifdef WSHB_ARBITER_ROUND_ROBIN_EN
  // 1 = master 1 has priority on the next tie.
  logic          prio_q, prio_d;
`endif

  logic xfer;
  logic win_m1;
  logic [CW-1:0] cnt_inc;

  assign xfer    = s_ack | s_err;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ho_d    = ho_q;
    win_m1  = 1'b0;
`ifdef WSHB_ARBITER_ROUND_ROBIN_EN
    prio_d  = prio_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_cyc || m1_cyc) begin
          if (!(m0_cyc && m1_cyc)) win_m1 = m1_cyc;
          else if (|ho_q)          win_m1 = ho_q[1];
          else begin
`ifdef WSHB_ARBITER_ROUND_ROBIN_EN
            win_m1 = prio_q;
`else
            win_m1 = 1'b0;
`endif
          end
          state_d = win_m1 ? G1 : G0;
          // Any grant consumes a pending handover; if the waiting master
          // left, the remaining one is served rather than stalling.
          ho_d    = 2'b00;
`ifdef WSHB_ARBITER_ROUND_ROBIN_EN
          prio_d  = ~win_m1;
`endif
        end
      end
      G0: begin
        if (xfer) cnt_d = cnt_inc;
        if (!m0_cyc) state_d = IDLE;
        else if ((MAX_BURST > 0) && xfer && m1_cyc && (cnt_q >= CNT_LAST)) begin
          state_d = IDLE;
          ho_d    = 2'b10;
        end
      end
      G1: begin
        if (xfer) cnt_d = cnt_inc;
        if (!m1_cyc) state_d = IDLE;
        else if ((MAX_BURST > 0) && xfer && m0_cyc && (cnt_q >= CNT_LAST)) begin
          state_d = IDLE;
          ho_d    = 2'b01;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Routing depends on the registered owner only, so reset blanks it at once.
  always_comb begin
    s_req  = '0;
    m0_ack = 1'b0;
    m0_err = 1'b0;
    m1_ack = 1'b0;
    m1_err = 1'b0;
    grant  = 2'b00;
    case (state_q)
      G0: begin
        s_req  = m0_req;
        m0_ack = s_ack;
        m0_err = s_err;
        grant  = 2'b01;
      end
      G1: begin
        s_req  = m1_req;
        m1_ack = s_ack;
        m1_err = s_err;
        grant  = 2'b10;
      end
      default: ;
    endcase
  end

  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;

  always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
    if (!wshb_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ho_q    <= 2'b00;
`ifdef WSHB_ARBITER_ROUND_ROBIN_EN
      prio_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ho_q    <= ho_d;
`ifdef WSHB_ARBITER_ROUND_ROBIN_EN
      prio_q  <= prio_d;
`endif
    end
  end

endmodule

// File: tb/tb_wshb_arbiter.sv
module tb_wshb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat_ms, m1_adr, m1_dat_ms;
  logic [3:0]  m0_sel, m1_sel;
  logic [2:0]  m0_cti, m1_cti;
  logic [1:0]  m0_bte, m1_bte;
  logic [31:0] s_dat_sm;
  logic        s_ack, s_err;

  logic [31:0] m0_dat_sm, m1_dat_sm, s_adr, s_dat_ms;
  logic        m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte, grant;

  // Second instance with preemption disabled, sharing all inputs.
  logic [31:0] n_m0_dat_sm, n_m1_dat_sm, n_s_adr, n_s_dat_ms;
  logic        n_m0_ack, n_m0_err, n_m1_ack, n_m1_err, n_s_cyc, n_s_stb, n_s_we;
  logic [3:0]  n_s_sel;
  logic [2:0]  n_s_cti;
  logic [1:0]  n_s_bte, n_grant;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  wshb_arbiter #(.MAX_BURST(4)) dut (
    .wshb_clk(clk), .wshb_rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_dat_sm(m0_dat_sm), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_dat_sm(m1_dat_sm), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
    .s_dat_sm(s_dat_sm), .s_ack(s_ack), .s_err(s_err), .grant(grant)
  );

  wshb_arbiter #(.MAX_BURST(0)) u_nop (
    .wshb_clk(clk), .wshb_rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte),
    .m0_dat_sm(n_m0_dat_sm), .m0_ack(n_m0_ack), .m0_err(n_m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte),
    .m1_dat_sm(n_m1_dat_sm), .m1_ack(n_m1_ack), .m1_err(n_m1_err),
    .s_cyc(n_s_cyc), .s_stb(n_s_stb), .s_we(n_s_we), .s_adr(n_s_adr),
    .s_dat_ms(n_s_dat_ms), .s_sel(n_s_sel), .s_cti(n_s_cti), .s_bte(n_s_bte),
    .s_dat_sm(s_dat_sm), .s_ack(s_ack), .s_err(s_err), .grant(n_grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 32'h0; m0_dat_ms = 32'h0;
    m0_sel = 4'h0; m0_cti = 3'h0; m0_bte = 2'h0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 32'h0; m1_dat_ms = 32'h0;
    m1_sel = 4'h0; m1_cti = 3'h0; m1_bte = 2'h0;
    s_ack = 0; s_err = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    m0_adr = 32'h1234_5678;
    s_ack = 1; s_dat_sm = 32'hA5A5_0001;
    repeat (3) tick();
    total_cnt++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant); else pass_cnt++;
    total_cnt++; if (s_cyc !== 1'b0) $display("FAIL reset_s_cyc: got %b want 0", s_cyc); else pass_cnt++;
    total_cnt++; if (s_adr !== 32'h0) $display("FAIL reset_s_adr: got %h want 0", s_adr); else pass_cnt++;
    total_cnt++; if ({m0_ack, m1_ack} !== 2'b00) $display("FAIL reset_acks: got %b want 00", {m0_ack, m1_ack}); else pass_cnt++;
    total_cnt++; if (m1_dat_sm !== 32'hA5A5_0001) $display("FAIL reset_dat_sm: got %h want a5a50001", m1_dat_sm); else pass_cnt++;
    @(negedge clk);
    rst_n = 1;
    s_ack = 0;
    tick();
  endtask

  task automatic test_m1_only();
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'hCAFE_0010; m1_dat_ms = 32'h0BAD_F00D;
    m1_sel = 4'hC; m1_cti = 3'h2; m1_bte = 2'h1;
    #1;
    total_cnt++; if (grant !== 2'b00) $display("FAIL m1_latency: got %b want 00", grant); else pass_cnt++;
    tick();
    total_cnt++; if (grant !== 2'b10) $display("FAIL m1_grant: got %b want 10", grant); else pass_cnt++;
    total_cnt++; if (s_adr !== 32'hCAFE_0010) $display("FAIL m1_s_adr: got %h want cafe0010", s_adr); else pass_cnt++;
    total_cnt++; if ({s_cyc, s_stb, s_we, s_sel, s_cti, s_bte} !== {3'b111, 4'hC, 3'h2, 2'h1})
      $display("FAIL m1_ctrl: got %b want %b", {s_cyc, s_stb, s_we, s_sel, s_cti, s_bte}, {3'b111, 4'hC, 3'h2, 2'h1}); else pass_cnt++;
    total_cnt++; if (s_dat_ms !== 32'h0BAD_F00D) $display("FAIL m1_s_dat: got %h want 0badf00d", s_dat_ms); else pass_cnt++;
    total_cnt++; if (m1_ack !== 1'b0) $display("FAIL m1_ack_low: got %b want 0", m1_ack); else pass_cnt++;
    s_ack = 1; s_dat_sm = 32'h5555_AAAA;
    #1;
    total_cnt++; if ({m0_ack, m1_ack} !== 2'b01) $display("FAIL m1_ack_follow: got %b want 01", {m0_ack, m1_ack}); else pass_cnt++;
    total_cnt++; if (m0_dat_sm !== 32'h5555_AAAA) $display("FAIL m0_dat_sm_shared: got %h want 5555aaaa", m0_dat_sm); else pass_cnt++;
    s_ack = 0;
    clear_inputs();
    tick();
    total_cnt++; if (grant !== 2'b00) $display("FAIL m1_release: got %b want 00", grant); else pass_cnt++;
  endtask

  task automatic test_idle_ack();
    s_ack = 1;
    #1;
    total_cnt++; if ({m0_ack, m1_ack} !== 2'b00) $display("FAIL idle_ack_fwd: got %b want 00", {m0_ack, m1_ack}); else pass_cnt++;
    tick();
    total_cnt++; if (dut.cnt_q !== 3'd0) $display("FAIL idle_cnt: got %0d want 0", dut.cnt_q); else pass_cnt++;
    s_ack = 0;
  endtask

  task automatic test_burst();
    logic [1:0] exp_tbl [14] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                                 2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
                                 2'b01, 2'b01, 2'b01, 2'b01};
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
    for (int c = 0; c < 14; c++) begin
      tick();
      total_cnt++; if (grant !== exp_tbl[c]) $display("FAIL burst_grant[%0d]: got %b want %b", c, grant, exp_tbl[c]); else pass_cnt++;
      total_cnt++; if ({m1_ack, m0_ack, s_cyc} !== {exp_tbl[c], |exp_tbl[c]})
        $display("FAIL burst_ack[%0d]: got %b want %b", c, {m1_ack, m0_ack, s_cyc}, {exp_tbl[c], |exp_tbl[c]}); else pass_cnt++;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_err_handover();
    m0_cyc = 1; m0_stb = 1;
    tick();
    total_cnt++; if (grant !== 2'b01) $display("FAIL err_g0: got %b want 01", grant); else pass_cnt++;
    s_ack = 1;
    repeat (3) tick();
    s_ack = 0; s_err = 1; m1_cyc = 1; m1_stb = 1;
    #1;
    total_cnt++; if ({m0_err, m0_ack, m1_err} !== 3'b100) $display("FAIL err_fwd: got %b want 100", {m0_err, m0_ack, m1_err}); else pass_cnt++;
    tick();
    total_cnt++; if ({grant, s_cyc, m0_err} !== 4'b0000) $display("FAIL err_idle: got %b want 0000", {grant, s_cyc, m0_err}); else pass_cnt++;
    s_err = 0;
    tick();
    total_cnt++; if (grant !== 2'b10) $display("FAIL err_handover: got %b want 10", grant); else pass_cnt++;
    s_ack = 1;
    #1;
    total_cnt++; if ({m0_ack, m1_ack} !== 2'b01) $display("FAIL preempted_no_ack: got %b want 01", {m0_ack, m1_ack}); else pass_cnt++;
    clear_inputs();
    tick();
  endtask

  task automatic test_priority();
    logic [1:0] exp_first, exp_second;
`ifdef WSHB_ARBITER_ROUND_ROBIN_EN
    exp_first = 2'b10;
`else
    exp_first = 2'b01;
`endif
    exp_second = ~exp_first;
    m0_cyc = 1; m0_stb = 1;
    tick();
    clear_inputs();
    tick();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    tick();
    total_cnt++; if (grant !== exp_first) $display("FAIL prio_first: got %b want %b", grant, exp_first); else pass_cnt++;
    s_ack = 1;
    repeat (2) tick();
    s_ack = 0;
    if (exp_first == 2'b01) begin m0_cyc = 0; m0_stb = 0; end
    else begin m1_cyc = 0; m1_stb = 0; end
    tick();
    total_cnt++; if (grant !== 2'b00) $display("FAIL prio_idle: got %b want 00", grant); else pass_cnt++;
    tick();
    total_cnt++; if (grant !== exp_second) $display("FAIL prio_second: got %b want %b", grant, exp_second); else pass_cnt++;
    clear_inputs();
    tick();
  endtask

  task automatic test_no_preempt();
    logic [1:0] first;
    tick();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
    tick();
    first = n_grant;
    total_cnt++; if (first !== 2'b01 && first !== 2'b10) $display("FAIL nop_grant: got %b want one-hot", first); else pass_cnt++;
    for (int c = 0; c < 8; c++) begin
      tick();
      total_cnt++; if (n_grant !== first) $display("FAIL nop_hold[%0d]: got %b want %b", c, n_grant, first); else pass_cnt++;
    end
    clear_inputs();
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    m0_cyc = 1; m0_stb = 1;
    tick();
    total_cnt++; if (grant !== 2'b01) $display("FAIL rmid_g0: got %b want 01", grant); else pass_cnt++;
    s_ack = 1;
    #2 rst_n = 0;
    #1;
    total_cnt++; if ({s_cyc, grant, m0_ack} !== 4'b0000) $display("FAIL rmid_async: got %b want 0000", {s_cyc, grant, m0_ack}); else pass_cnt++;
    total_cnt++; if (dut.cnt_q !== 3'd0) $display("FAIL rmid_cnt: got %0d want 0", dut.cnt_q); else pass_cnt++;
    tick();
    total_cnt++; if ({grant, m0_ack} !== 3'b000) $display("FAIL rmid_hold: got %b want 000", {grant, m0_ack}); else pass_cnt++;
    #2 rst_n = 1;
    s_ack = 0;
    tick();
    total_cnt++; if (grant !== 2'b01) $display("FAIL rmid_regrant: got %b want 01", grant); else pass_cnt++;
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_m1_only();
    test_idle_ack();
    test_burst();
    test_err_handover();
    test_priority();
    test_no_preempt();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
